// File: rtl/striping_pkg.sv
// Shared constants for the 2-lane striping controller.
package striping_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_STALL  = 2'd2
   } state_t;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

   localparam int unsigned MAX_CREDITS_DEF = 4;

endpackage

// File: rtl/lane_credit_cnt.sv
// Per-lane credit counter: decrement on push, increment on return, saturating
// at MAX_CREDITS with a sticky error flag for an over-return.
module lane_credit_cnt #(
   parameter int unsigned MAX_CREDITS = 4,
   parameter int unsigned CREDIT_W    = 3
) (
   input  logic                clk_2f,
   input  logic                reset_L,
   input  logic                push,
   input  logic                credit_return,
   output logic [CREDIT_W-1:0] credits,
   output logic                has_credit,
   output logic                credit_err
);

   localparam logic [CREDIT_W-1:0] MaxVal = CREDIT_W'(MAX_CREDITS);

   logic [CREDIT_W-1:0] cnt_q, cnt_d;
   logic                err_q, err_d;

   // Next credit value; push and return in the same cycle cancel out.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (push && !credit_return) begin
         cnt_d = cnt_q - CREDIT_W'(1);
      end else if (credit_return && !push) begin
         if (cnt_q == MaxVal) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CREDIT_W'(1);
         end
      end
   end

   // Credit and error registers.
   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         cnt_q <= MaxVal;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign credits    = cnt_q;
   assign has_credit = (cnt_q != '0);
   assign credit_err = err_q;

endmodule

// File: rtl/striping_lane_ctrl.sv
// Lane sequencer for the 2-lane striping demux: picks the lane of each accepted
// word, applies per-lane credit flow control and realigns to lane 0 per burst.
module striping_lane_ctrl
   import striping_pkg::*;
#(
   parameter int unsigned MAX_CREDITS = MAX_CREDITS_DEF,
   parameter int unsigned CREDIT_W    = 3,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                clk_2f,
   input  logic                reset_L,
   input  logic                valid_in,
   output logic                ready_in,
   input  logic                credit_return_0,
   input  logic                credit_return_1,
   output logic                selector,
   output logic                push_0,
   output logic                push_1,
   output logic [CREDIT_W-1:0] credits_0,
   output logic [CREDIT_W-1:0] credits_1,
   output logic [1:0]          state,
   output logic [CNT_W-1:0]    word_count,
   output logic                credit_err
);

   state_t           state_q, state_d;
   logic             sel_q, sel_d;
   logic [CNT_W-1:0] wc_q;
   logic             has_credit_0, has_credit_1;
   logic             err_0, err_1;
   logic             accept;

   // Handshake and zero-latency push strobes; reset_L gates pushes while held low.
   always_comb begin
      ready_in = sel_q ? has_credit_1 : has_credit_0;
      accept   = valid_in & ready_in & reset_L;
      push_0   = accept & (sel_q == LANE0);
      push_1   = accept & (sel_q == LANE1);
   end

   lane_credit_cnt #(
      .MAX_CREDITS (MAX_CREDITS),
      .CREDIT_W    (CREDIT_W)
   ) u_credit_0 (
      .clk_2f        (clk_2f),
      .reset_L       (reset_L),
      .push          (push_0),
      .credit_return (credit_return_0),
      .credits       (credits_0),
      .has_credit    (has_credit_0),
      .credit_err    (err_0)
   );

   lane_credit_cnt #(
      .MAX_CREDITS (MAX_CREDITS),
      .CREDIT_W    (CREDIT_W)
   ) u_credit_1 (
      .clk_2f        (clk_2f),
      .reset_L       (reset_L),
      .push          (push_1),
      .credit_return (credit_return_1),
      .credits       (credits_1),
      .has_credit    (has_credit_1),
      .credit_err    (err_1)
   );

   // Next state and selector: toggle on accept, freeze on stall, realign on a gap.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      case (state_q)
         ST_IDLE: begin
            sel_d = LANE0;
            if (accept) begin
               state_d = ST_ACTIVE;
               sel_d   = LANE1;
            end else if (valid_in) begin
               state_d = ST_STALL;
            end
         end
         ST_ACTIVE, ST_STALL: begin
            if (accept) begin
               state_d = ST_ACTIVE;
               sel_d   = ~sel_q;
            end else if (valid_in) begin
               state_d = ST_STALL;
            end else begin
               state_d = ST_IDLE;
               sel_d   = LANE0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = LANE0;
         end
      endcase
   end

   // State, selector and accepted-word counter registers.
   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= ST_IDLE;
         sel_q   <= LANE0;
         wc_q    <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         if (accept) begin
            wc_q <= wc_q + CNT_W'(1);
         end
      end
   end

   assign selector   = sel_q;
   assign state      = state_q;
   assign word_count = wc_q;
   assign credit_err = err_0 | err_1;

endmodule

// File: tb/tb_striping_lane_ctrl.sv
// Bench for striping_lane_ctrl: directed scenarios plus random traffic, all
// compared every cycle against a burst-position / credit-table reference model.
module tb_striping_lane_ctrl;

   logic        clk_2f = 1'b0;
   logic        reset_L = 1'b0;
   logic        valid_in = 1'b0;
   logic        credit_return_0 = 1'b0;
   logic        credit_return_1 = 1'b0;
   logic        ready_in, selector, push_0, push_1, credit_err;
   logic [2:0]  credits_0, credits_1;
   logic [1:0]  state;
   logic [15:0] word_count;

   striping_lane_ctrl #(
      .MAX_CREDITS (4),
      .CREDIT_W    (3),
      .CNT_W       (16)
   ) dut (
      .clk_2f          (clk_2f),
      .reset_L         (reset_L),
      .valid_in        (valid_in),
      .ready_in        (ready_in),
      .credit_return_0 (credit_return_0),
      .credit_return_1 (credit_return_1),
      .selector        (selector),
      .push_0          (push_0),
      .push_1          (push_1),
      .credits_0       (credits_0),
      .credits_1       (credits_1),
      .state           (state),
      .word_count      (word_count),
      .credit_err      (credit_err)
   );

   always #5 clk_2f = ~clk_2f;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: lane = parity of words accepted since the burst began.
   int m_cred [2];
   int m_wc;
   int m_err;
   int m_burst_pos;
   int m_state;   // 0 idle, 1 last cycle accepted, 2 last cycle waited

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cred[0] = 4;
      m_cred[1] = 4;
      m_wc = 0;
      m_err = 0;
      m_burst_pos = 0;
      m_state = 0;
   endtask

   function automatic int exp_lane();
      return m_burst_pos % 2;
   endfunction

   task automatic check_outputs();
      int lane;
      int rdy;
      int acc;
      lane = exp_lane();
      rdy = (m_cred[lane] != 0) ? 1 : 0;
      acc = (valid_in && rdy != 0 && reset_L) ? 1 : 0;
      check_eq("selector", 32'(selector), 32'(lane));
      check_eq("ready_in", 32'(ready_in), 32'(rdy));
      check_eq("push_0", 32'(push_0), 32'((acc != 0) && lane == 0));
      check_eq("push_1", 32'(push_1), 32'((acc != 0) && lane == 1));
      check_eq("credits_0", 32'(credits_0), 32'(m_cred[0]));
      check_eq("credits_1", 32'(credits_1), 32'(m_cred[1]));
      check_eq("state", 32'(state), 32'(m_state));
      check_eq("word_count", 32'(word_count), 32'(m_wc));
      check_eq("credit_err", 32'(credit_err), 32'(m_err));
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      int lane;
      int acc;
      int push [2];
      int ret [2];
      if (!reset_L) begin
         model_reset();
         return;
      end
      lane = exp_lane();
      acc = (valid_in && m_cred[lane] != 0) ? 1 : 0;
      push[0] = (acc != 0 && lane == 0) ? 1 : 0;
      push[1] = (acc != 0 && lane == 1) ? 1 : 0;
      ret[0] = int'(credit_return_0);
      ret[1] = int'(credit_return_1);
      for (int k = 0; k < 2; k++) begin
         if (push[k] != 0 && ret[k] == 0) m_cred[k]--;
         else if (ret[k] != 0 && push[k] == 0) begin
            if (m_cred[k] == 4) m_err = 1;
            else m_cred[k]++;
         end
      end
      if (acc != 0) begin
         m_wc = (m_wc + 1) % 65536;
         m_burst_pos++;
         m_state = 1;
      end else if (valid_in) begin
         m_state = 2;
      end else begin
         m_state = 0;
         m_burst_pos = 0;
      end
   endtask

   task automatic cyc(input logic v, input logic c0, input logic c1);
      valid_in = v;
      credit_return_0 = c0;
      credit_return_1 = c1;
      @(negedge clk_2f);
      check_outputs();
      model_step();
      @(posedge clk_2f);
      #1;
   endtask

   task automatic do_reset();
      reset_L = 1'b0;
      model_reset();
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      reset_L = 1'b1;
   endtask

   initial begin
      model_reset();
      @(posedge clk_2f);
      #1;
      do_reset();
      check_eq("reset_credits_0", 32'(credits_0), 32'd4);
      check_eq("reset_state", 32'(state), 32'd0);

      // Four-word burst, no returns.
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      check_eq("burst4_credits_0", 32'(credits_0), 32'd2);
      check_eq("burst4_credits_1", 32'(credits_1), 32'd2);
      check_eq("burst4_wc", 32'(word_count), 32'd4);
      check_eq("burst4_state", 32'(state), 32'd0);

      // Nine-word burst stalls on lane 0, one return releases it.
      do_reset();
      for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0);
      check_eq("stall_state", 32'(state), 32'd2);
      check_eq("stall_ready", 32'(ready_in), 32'd0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      check_eq("stall_release_wc", 32'(word_count), 32'd9);
      cyc(1'b0, 1'b0, 1'b0);

      // Burst of 3, one-cycle gap, burst of 2: second burst realigns to lane 0.
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      check_eq("realign_credits_0", 32'(credits_0), 32'd1);
      check_eq("realign_credits_1", 32'(credits_1), 32'd2);

      // Push and return on lane 0 together; over-return on lane 1.
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      check_eq("simul_credits_0", 32'(credits_0), 32'd3);
      check_eq("simul_credits_1", 32'(credits_1), 32'd4);
      check_eq("over_return_err", 32'(credit_err), 32'd1);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);

      // Reset pulled low between edges in the middle of a burst.
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      reset_L = 1'b0;
      model_reset();
      #1;
      check_outputs();
      cyc(1'b1, 1'b0, 1'b0);
      reset_L = 1'b1;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);

      // Random traffic with periodic resets.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 600 == 599) do_reset();
         cyc(logic'($urandom_range(0, 99) < 75),
             logic'($urandom_range(0, 99) < 30),
             logic'($urandom_range(0, 99) < 30));
      end

      // Word counter wrap: return credit to the pushed lane every cycle.
      do_reset();
      for (int i = 0; i < 65536; i++) begin
         cyc(1'b1, logic'(exp_lane() == 0), logic'(exp_lane() == 1));
      end
      check_eq("wrap_wc", 32'(word_count), 32'd0);
      check_eq("wrap_err", 32'(credit_err), 32'd0);
      cyc(1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/striping_lane_ctrl.md
Name: striping_lane_ctrl

Overview:
- Control-only sequencer for the 2-lane byte-striping demux: decides which lane (0/1) each accepted 32-bit word goes to, and drives the demux `selector` plus per-lane push strobes.
- Enforces credit-based flow control toward the two downstream lane FIFOs and backpressures upstream via `ready_in`.
- Realigns striping to lane 0 at the start of every burst.
- Sits between the upstream valid source and the striping demux, in the clk_2f domain.

Parameters:
- MAX_CREDITS, 4: credits per lane after reset (downstream FIFO depth).
- CREDIT_W, 3: credit counter width; must hold MAX_CREDITS.
- CNT_W, 16: accepted-word counter width.

Ports:
- clk_2f  input  1  sole clock, rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- valid_in  input  1  upstream word valid.
- ready_in  output  1  controller can accept the word this cycle.
- credit_return_0  input  1  one-cycle pulse: lane 0 FIFO freed one entry.
- credit_return_1  input  1  one-cycle pulse: lane 1 FIFO freed one entry.
- selector  output  1  demux lane select (0 = data_out0, 1 = data_out1).
- push_0  output  1  lane 0 write strobe.
- push_1  output  1  lane 1 write strobe.
- credits_0  output  CREDIT_W  lane 0 available credits.
- credits_1  output  CREDIT_W  lane 1 available credits.
- state  output  2  FSM state (IDLE=0, ACTIVE=1, STALL=2).
- word_count  output  CNT_W  total accepted words, wraps modulo 2^CNT_W.
- credit_err  output  1  sticky: credit returned to a lane already at MAX_CREDITS.

Behaviour:
- Clocking and reset
  - All state updates on posedge clk_2f.
  - reset_L low forces asynchronously: selector=0, state=IDLE, credits_0=credits_1=MAX_CREDITS, word_count=0, credit_err=0.
  - push_0, push_1 and ready_in follow combinationally from the reset state.
- Combinational outputs
  - ready_in = (selector ? credits_1 : credits_0) != 0.
  - accept = valid_in & ready_in.
  - push_0 = accept & ~selector; push_1 = accept & selector.
  - Zero-latency: the strobe is asserted in the same cycle the demux samples data.
- Credits, per lane, registered
  - Next value = current − push_k + credit_return_k.
  - Push and return in the same cycle: value unchanged.
  - Return while at MAX_CREDITS with no push: value stays MAX_CREDITS and credit_err is set (sticky until reset).
  - Credits never underflow, because push requires a nonzero credit.
- word_count: increments by 1 on every accept and wraps.
- FSM
  - IDLE: selector held 0. valid_in & ready_in → ACTIVE, selector←1. valid_in & ~ready_in → STALL, selector stays 0. Otherwise stay.
  - ACTIVE: accept → selector toggles, stay ACTIVE. valid_in & ~ready_in → STALL. valid_in=0 → IDLE, selector←0 (burst realignment).
  - STALL: ready_in=0 and selector frozen. When target-lane credit becomes nonzero (registered), ready_in rises. Next accept → ACTIVE, selector toggles. valid_in=0 → IDLE, selector←0.
- Boundary cases
  - A single-word burst always lands on lane 0.
  - A valid_in gap of one cycle restarts the next burst on lane 0.
  - reset_L asserted mid-burst abandons the in-flight sequence immediately; no push is issued while reset is low.
  - An upstream change of valid_in during STALL is legal; no word is lost because no accept occurs.

Decomposition:
- Shared package striping_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ACTIVE=2'd1, ST_STALL=2'd2;
  - lane index constants LANE0=1'b0, LANE1=1'b1;
  - default MAX_CREDITS.
- One natural sub-module, lane_credit_cnt, instantiated twice. It provides an up/down credit counter with saturation, error flag and a `has_credit` output.
- The FSM, selector logic and word_count stay in the top module.

Test Plan:
- Reset, then 4 consecutive valid words 0xEEEEEEEE..0xEEEEEEF1 with no credit returns:
  - pushes go to lanes 0,1,0,1;
  - credits_0=credits_1=2; word_count=4; state ends IDLE after valid_in drops; selector=0.
- 9-word burst with no returns:
  - words 1–8 accepted, alternating lanes;
  - word 9 (lane 0, credits_0=0) gives ready_in=0 and state=STALL;
  - one credit_return_0 pulse gives ready_in=1 on the next cycle, the word is pushed to lane 0 and word_count=9.
- Burst of 3, valid_in low 1 cycle, burst of 2:
  - lanes are 0,1,0 then 0,1 (realignment);
  - credits_0=1, credits_1=2.
- Simultaneous push_0 and credit_return_0 with credits_0=3: credits_0 stays 3. credit_return_1 with credits_1=4: credits_1 stays 4 and credit_err=1 persists.
- Reset mid-burst:
  - after 2 accepts, pull reset_L low between clock edges;
  - selector, state, word_count and credit_err clear immediately, credits return to 4, push_0/push_1 stay 0 while reset is low;
  - after release, the next word goes to lane 0.
- word_count wrap: preload via 65536 accepts with credits returned every cycle → word_count=0 and no credit_err.
